// File: rtl/seg7_scan_if.sv
// Bundle between the ATM pattern source and the multiplexed 7-segment scan driver.
// The master side supplies the digit patterns and display modes. The slave side drives the display pins.
interface seg7_scan_if;
    logic [6:0] digit1;
    logic [6:0] digit2;
    logic [6:0] digit3;
    logic [6:0] digit4;
    logic [3:0] dp_mask;
    logic       blank;
    logic       blink;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output digit1, digit2, digit3, digit4, dp_mask, blank, blink,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  digit1, digit2, digit3, digit4, dp_mask, blank, blink,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four frame-latched digit patterns onto a common-anode 4-digit display.
// It also provides an anti-ghost guard time, blanking and a frame-based blink mode.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 2000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BC_W  = $clog2(BLINK_FRAMES) + 1;

    localparam logic [0:0] PHASE_ON  = 1'b0;
    localparam logic [0:0] PHASE_OFF = 1'b1;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       slot_r;
    logic [6:0]       shadow_r [4];
    logic [3:0]       shadow_dp_r;
    logic [BC_W-1:0]  blink_cnt_r;
    logic [0:0]       phase_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic [3:0]       an_r;
    logic             frame_tick_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       slot_nxt_s;
    logic             wrap_s;
    logic             frame_s;
    logic [6:0]       shadow_nxt_s [4];
    logic [3:0]       shadow_dp_nxt_s;
    logic [BC_W-1:0]  blink_cnt_nxt_s;
    logic [0:0]       phase_nxt_s;
    logic             visible_s;
    logic [6:0]       seg_nxt_s;
    logic             dp_nxt_s;
    logic [3:0]       an_nxt_s;

    // Next-state for scan counters, frame latch and blink phase
    always_comb begin
        wrap_s          = (cnt_r == CNT_W'(REFRESH_DIV - 1));
        frame_s         = wrap_s && (slot_r == 2'd3);
        cnt_nxt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        slot_nxt_s      = slot_r;
        shadow_dp_nxt_s = shadow_dp_r;
        blink_cnt_nxt_s = blink_cnt_r;
        phase_nxt_s     = phase_r;
        for (int i = 0; i < 4; i++) begin
            shadow_nxt_s[i] = shadow_r[i];
        end

        if (wrap_s) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            slot_nxt_s = slot_r + 2'd1;
        end else begin
            slot_nxt_s = slot_r;
        end

        if (frame_s) begin
            shadow_nxt_s[0] = bus.digit1;
            shadow_nxt_s[1] = bus.digit2;
            shadow_nxt_s[2] = bus.digit3;
            shadow_nxt_s[3] = bus.digit4;
            shadow_dp_nxt_s = bus.dp_mask;
        end else begin
            shadow_dp_nxt_s = shadow_dp_r;
        end

        // Dropping blink restarts the next episode from a full ON half-period
        if (!bus.blink) begin
            blink_cnt_nxt_s = {BC_W{1'b0}};
            phase_nxt_s     = PHASE_ON;
        end else if (frame_s) begin
            if (blink_cnt_r == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt_s = {BC_W{1'b0}};
                case (phase_r)
                    PHASE_ON:  phase_nxt_s = PHASE_OFF;
                    PHASE_OFF: phase_nxt_s = PHASE_ON;
                    default:   phase_nxt_s = PHASE_ON;
                endcase
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Output decode from next-state so the registered pins line up with cnt/slot
    always_comb begin
        visible_s = !bus.blank
                    && !(bus.blink && (phase_nxt_s == PHASE_OFF))
                    && (cnt_nxt_s >= CNT_W'(GUARD));
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        an_nxt_s  = 4'b1111;
        if (visible_s) begin
            seg_nxt_s = ~shadow_nxt_s[slot_nxt_s];
            dp_nxt_s  = ~shadow_dp_nxt_s[slot_nxt_s];
            case (slot_nxt_s)
                2'd0:    an_nxt_s = 4'b1110;
                2'd1:    an_nxt_s = 4'b1101;
                2'd2:    an_nxt_s = 4'b1011;
                2'd3:    an_nxt_s = 4'b0111;
                default: an_nxt_s = 4'b1111;
            endcase
        end else begin
            an_nxt_s = 4'b1111;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            slot_r       <= 2'd0;
            shadow_dp_r  <= 4'b0000;
            blink_cnt_r  <= {BC_W{1'b0}};
            phase_r      <= PHASE_ON;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= 4'b1111;
            frame_tick_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 7'h00;
            end
        end else begin
            cnt_r        <= cnt_nxt_s;
            slot_r       <= slot_nxt_s;
            shadow_dp_r  <= shadow_dp_nxt_s;
            blink_cnt_r  <= blink_cnt_nxt_s;
            phase_r      <= phase_nxt_s;
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            an_r         <= an_nxt_s;
            frame_tick_r <= frame_s;
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
            end
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.an         = an_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver. A time-indexed reference model predicts every output on every cycle.
// Directed scenarios run first, followed by a randomized run.
module tb_seg7_scan_driver;

    localparam int R  = 4;
    localparam int G  = 1;
    localparam int BF = 2;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    // reference model state: cycles since reset, latched frame content, blink bookkeeping
    int         m_t;
    logic [6:0] m_sh [4];
    logic [3:0] m_dp;
    int         m_bc;
    bit         m_on;
    int         m_cnt;
    int         m_slot;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;
    logic       exp_ft;

    seg7_scan_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV  (R),
        .GUARD        (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_update();
        bit boundary;
        bit vis;
        if (!rst) begin
            m_t = 0;
            m_cnt = 0;
            m_slot = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 7'h00;
            m_dp = 4'b0000;
            m_bc = 0;
            m_on = 1'b1;
            exp_an = 4'b1111;
            exp_seg = 7'h7F;
            exp_dp = 1'b1;
            exp_ft = 1'b0;
        end else begin
            boundary = ((m_t % (4 * R)) == (4 * R - 1));
            m_t = m_t + 1;
            m_cnt = m_t % R;
            m_slot = (m_t / R) % 4;
            if (boundary) begin
                m_sh[0] = bus.digit1;
                m_sh[1] = bus.digit2;
                m_sh[2] = bus.digit3;
                m_sh[3] = bus.digit4;
                m_dp = bus.dp_mask;
            end
            exp_ft = boundary;
            if (!bus.blink) begin
                m_bc = 0;
                m_on = 1'b1;
            end else if (boundary) begin
                if (m_bc == BF - 1) begin
                    m_bc = 0;
                    m_on = !m_on;
                end else begin
                    m_bc = m_bc + 1;
                end
            end
            vis = !bus.blank && !(bus.blink && !m_on) && (m_cnt >= G);
            if (vis) begin
                exp_an = 4'b1111 ^ (4'b0001 << m_slot);
                exp_seg = ~m_sh[m_slot];
                exp_dp = ~m_dp[m_slot];
            end else begin
                exp_an = 4'b1111;
                exp_seg = 7'h7F;
                exp_dp = 1'b1;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, m_t, obs, expv);
        end
    endtask

    // one clock: model consumes the inputs sampled at the edge, then outputs are compared 1 ns later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_val("an", {3'b000, bus.an}, {3'b000, exp_an});
        check_val("seg", bus.seg, exp_seg);
        check_val("dp", {6'b0, bus.dp}, {6'b0, exp_dp});
        check_val("frame_tick", {6'b0, bus.frame_tick}, {6'b0, exp_ft});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int slot, input int cnt);
        for (int i = 0; i < 4 * R + 1; i++) begin
            if (m_slot == slot && m_cnt == cnt) break;
            step();
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.digit1 = 7'h00;
        bus.digit2 = 7'h00;
        bus.digit3 = 7'h00;
        bus.digit4 = 7'h00;
        bus.dp_mask = 4'b0000;
        bus.blank = 1'b0;
        bus.blink = 1'b0;
        #2;

        // reset held three cycles, then scan pattern applied
        run(3);
        rst = 1'b1;
        bus.digit1 = 7'h06;
        bus.digit2 = 7'h5B;
        bus.digit3 = 7'h4F;
        bus.digit4 = 7'h66;
        bus.dp_mask = 4'b0001;
        run(15);
        // the final step of the first frame lands on the boundary edge, so frame_tick is high here
        step();
        check_val("first_tick", {6'b0, bus.frame_tick}, 7'h01);
        step();
        check_val("slot0_an", {3'b000, bus.an}, 7'h0E);
        check_val("slot0_seg", bus.seg, 7'h79);
        check_val("slot0_dp", {6'b0, bus.dp}, 7'h00);
        run(16);

        // change digit3 mid-frame: slot 2 still shows the old pattern
        run_to(1, 1);
        bus.digit3 = 7'h7F;
        run_to(2, 2);
        check_val("no_tear", bus.seg, 7'h30);
        run(20);

        // blink episode, then drop blink while in the OFF half
        bus.blink = 1'b1;
        run(70);
        for (int i = 0; i < 64; i++) begin
            if (!m_on && m_cnt == 2) break;
            step();
        end
        bus.blink = 1'b0;
        step();
        check_val("blink_release", bus.seg, ~m_sh[m_slot]);
        run(10);

        // blank in slot 1, release in slot 3
        run_to(1, 1);
        bus.blank = 1'b1;
        step();
        check_val("blank_an", {3'b000, bus.an}, 7'h0F);
        run_to(3, 1);
        bus.blank = 1'b0;
        step();
        check_val("unblank_an", {3'b000, bus.an}, 7'h07);
        run(8);

        // reset mid-frame at slot 2, cnt 2
        run_to(2, 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        run(40);

        // randomized operation
        for (int i = 0; i < 1500; i++) begin
            bus.digit1 = 7'($urandom);
            bus.digit2 = 7'($urandom);
            bus.digit3 = 7'($urandom);
            bus.digit4 = 7'($urandom);
            bus.dp_mask = 4'($urandom);
            if ($urandom_range(0, 39) == 0) bus.blank = ~bus.blank;
            if ($urandom_range(0, 59) == 0) bus.blink = ~bus.blink;
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
